// File: rtl/masked_pkg.sv
// Shared constants, state type and LFSR helpers for the masked share source.
package masked_pkg;

   localparam int LFSR_W = 32;
   localparam logic [LFSR_W-1:0] SEED_DEFAULT = 32'hACE1_1234;
   localparam int MAX_STEPS = 16;

   localparam int TAP3 = 31;
   localparam int TAP2 = 21;
   localparam int TAP1 = 1;
   localparam int TAP0 = 0;

   // Bit positions in the advanced LFSR word used for masks and refresh bits.
   localparam int IDX_A_MASK = 0;
   localparam int IDX_B_MASK = 1;
   localparam int IDX_R0     = 2;
   localparam int IDX_R1     = 3;
   localparam int IDX_R2     = 4;

   typedef enum logic [0:0] {
      S_WARMUP = 1'b0,
      S_RUN    = 1'b1
   } state_e;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[TAP3] ^ s[TAP2] ^ s[TAP1] ^ s[TAP0]};
   endfunction

   function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s,
                                                      input int steps);
      logic [LFSR_W-1:0] t;
      t = s;
      for (int i = 0; i < MAX_STEPS; i++) begin
         if (i < steps) t = lfsr_step(t);
      end
      return t;
   endfunction

endpackage

// File: rtl/prng_lfsr.sv
// Seeded 32-bit Fibonacci LFSR that advances STEPS single-bit shifts per enabled cycle.
module prng_lfsr
   import masked_pkg::*;
#(
   parameter int LFSR_W = 32,
   parameter int STEPS  = 8,
   parameter logic [LFSR_W-1:0] SEED = 32'hACE1_1234
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              adv,
   output logic [LFSR_W-1:0] state
);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SEED;
      end else if (load) begin
         state <= load_val;
      end else if (adv) begin
         state <= lfsr_advance(state, STEPS);
      end
   end

endmodule

// File: rtl/masked_share_source.sv
// Turns plain a/b bits into first-order Boolean shares plus refresh bits, gated by a PRNG warm-up.
module masked_share_source
   import masked_pkg::*;
#(
   parameter int LFSR_W = 32,
   parameter logic [LFSR_W-1:0] SEED = 32'hACE1_1234,
   parameter int WARMUP = 16,
   parameter int STEPS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              a,
   input  logic              b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              a0,
   output logic              a1,
   output logic              b0,
   output logic              b1,
   output logic              r0,
   output logic              r1,
   output logic              r2,
   output logic              busy
);

   localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

   state_e            state_q;
   logic [7:0]        warm_cnt;
   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_n;
   logic [LFSR_W-1:0] seed_val;
   logic              accept;
   logic              adv;
   logic              unused_hi;

   assign seed_val = (seed_in == '0) ? SEED : seed_in;
   assign lfsr_n   = lfsr_advance(lfsr_q, STEPS);
   assign unused_hi = ^lfsr_n[LFSR_W-1:IDX_R2+1];

   assign busy     = (state_q == S_WARMUP);
   assign in_ready = (state_q == S_RUN) && !seed_load && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign adv      = busy || accept;

   prng_lfsr #(
      .LFSR_W (LFSR_W),
      .STEPS  (STEPS),
      .SEED   (SEED)
   ) u_prng (
      .clk      (clk),
      .rst      (rst),
      .load     (seed_load),
      .load_val (seed_val),
      .adv      (adv),
      .state    (lfsr_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_WARMUP;
         warm_cnt  <= '0;
         out_valid <= 1'b0;
         a0 <= 1'b0; a1 <= 1'b0; b0 <= 1'b0; b1 <= 1'b0;
         r0 <= 1'b0; r1 <= 1'b0; r2 <= 1'b0;
      end else if (seed_load) begin
         // A reseed drops any pending bundle; its masks came from the old stream.
         state_q   <= S_WARMUP;
         warm_cnt  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state_q)
            S_WARMUP: begin
               warm_cnt <= warm_cnt + 8'd1;
               if (warm_cnt == WARM_LAST) state_q <= S_RUN;
            end
            S_RUN: begin
               if (accept) begin
                  a0 <= a ^ lfsr_n[IDX_A_MASK];
                  a1 <= lfsr_n[IDX_A_MASK];
                  b0 <= b ^ lfsr_n[IDX_B_MASK];
                  b1 <= lfsr_n[IDX_B_MASK];
                  r0 <= lfsr_n[IDX_R0];
                  r1 <= lfsr_n[IDX_R1];
                  r2 <= lfsr_n[IDX_R2];
                  out_valid <= 1'b1;
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            default: state_q <= S_WARMUP;
         endcase
      end
   end

endmodule

// File: tb/tb_masked_share_source.sv
// Directed plus random bench for masked_share_source with a reference LFSR model and bundle scoreboard.
module tb_masked_share_source;

   localparam logic [31:0] SEED = 32'hACE1_1234;
   localparam logic [7:0]  PA   = 8'b0110_1101;
   localparam logic [7:0]  PB   = 8'b1010_0110;

   logic        clk = 1'b0;
   logic        rst, seed_load, in_valid, in_ready, a, b;
   logic        out_valid, out_ready, a0, a1, b0, b1, r0, r1, r2, busy;
   logic [31:0] seed_in;

   typedef struct packed {
      logic       a;
      logic       b;
      logic [6:0] bits;
   } exp_t;

   exp_t        sb[$];
   logic [6:0]  log_q[$];
   logic [6:0]  ref_q[$];
   logic [6:0]  seq1[$];
   logic [6:0]  seq1b[$];
   logic [6:0]  seq2[$];
   logic [31:0] m_lfsr;
   logic        m_run, m_valid;
   int          m_cnt;
   bit          logging = 0;
   bit          seen0[4], seen1[4];
   int          n_acc = 0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   masked_share_source dut (
      .clk       (clk),
      .rst       (rst),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a0        (a0),
      .a1        (a1),
      .b0        (b0),
      .b1        (b1),
      .r0        (r0),
      .r1        (r1),
      .r2        (r2),
      .busy      (busy)
   );

   function automatic logic [31:0] adv8(input logic [31:0] s);
      logic [31:0] t;
      t = s;
      for (int i = 0; i < 8; i++) t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_lfsr = SEED; m_run = 0; m_cnt = 0; m_valid = 0;
      sb.delete();
   endtask

   task automatic tick();
      logic exp_ready, acc, cons;
      logic [31:0] n;
      exp_t e;
      #1;
      exp_ready = m_run && !seed_load && (!m_valid || out_ready);
      if (!rst) chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(!m_run));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid && sb.size() > 0) begin
         e = sb[0];
         chk("bundle", 32'({a0, a1, b0, b1, r0, r1, r2}), 32'(e.bits));
         chk("inv_a", 32'(a0 ^ a1), 32'(e.a));
         chk("inv_b", 32'(b0 ^ b1), 32'(e.b));
      end
      acc  = !rst && in_valid && exp_ready;
      cons = !rst && !seed_load && m_valid && out_ready;
      if (cons) begin
         if (logging) log_q.push_back({a0, a1, b0, b1, r0, r1, r2});
         if (a1) seen1[0] = 1; else seen0[0] = 1;
         if (r0) seen1[1] = 1; else seen0[1] = 1;
         if (r1) seen1[2] = 1; else seen0[2] = 1;
         if (r2) seen1[3] = 1; else seen0[3] = 1;
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (seed_load) begin
         m_lfsr = (seed_in == 0) ? SEED : seed_in;
         m_run = 0; m_cnt = 0; m_valid = 0;
         sb.delete();
      end else if (!m_run) begin
         m_lfsr = adv8(m_lfsr);
         if (m_cnt == 15) m_run = 1;
         m_cnt++;
      end else begin
         if (cons && sb.size() > 0) void'(sb.pop_front());
         if (acc) begin
            n = adv8(m_lfsr);
            m_lfsr = n;
            e.a = a; e.b = b;
            e.bits = {a ^ n[0], n[0], b ^ n[1], n[1], n[2], n[3], n[4]};
            sb.push_back(e);
            m_valid = 1;
            n_acc++;
         end else if (cons) begin
            m_valid = 0;
         end
      end
      #1;
   endtask

   task automatic warm(input string tag);
      int wc;
      wc = 0;
      while (busy && wc < 40) begin
         tick();
         wc++;
      end
      chk(tag, 32'(wc), 32'd16);
   endtask

   task automatic stream(input bit first_check);
      logging = 1;
      log_q.delete();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; out_ready = 1; a = PA[i]; b = PB[i];
         tick();
         if (first_check && i == 0) begin
            chk("lat1_valid", 32'(out_valid), 32'd1);
            chk("lat1_a", 32'(a0 ^ a1), 32'd1);
            chk("lat1_b", 32'(b0 ^ b1), 32'd0);
         end
      end
      in_valid = 0;
      tick();
      logging = 0;
   endtask

   task automatic det_run(input logic [31:0] seed);
      seed_load = 1; seed_in = seed; in_valid = 0; out_ready = 1;
      tick();
      seed_load = 0;
      warm("warm_det");
      logging = 1;
      log_q.delete();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1; a = 0; b = 0;
         tick();
      end
      in_valid = 0;
      tick();
      logging = 0;
   endtask

   initial begin
      logic [69:0] s1, s2;
      int guard;
      rst = 1; seed_load = 0; seed_in = 0; in_valid = 0; a = 0; b = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("rst_outs", 32'({out_valid, a0, a1, b0, b1, r0, r1, r2}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);

      // Warm-up with in_valid held, then a fixed reference stream.
      rst = 0; in_valid = 1; out_ready = 1;
      warm("warm_rst");
      stream(1);
      ref_q = log_q;

      // Random traffic with random backpressure.
      guard = 0;
      n_acc = 0;
      while (n_acc < 1000 && guard < 5000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
         tick();
         guard++;
      end
      chk("rand_count", 32'(n_acc >= 1000), 32'd1);
      for (int i = 0; i < 4; i++) chk($sformatf("toggle%0d", i), 32'(seen0[i] && seen1[i]), 32'd1);
      in_valid = 0; out_ready = 1;
      tick();

      // Backpressure: one bundle held for five cycles, then consume+accept together.
      in_valid = 1; a = 1; b = 1; out_ready = 1;
      tick();
      out_ready = 0; a = 0; b = 1;
      repeat (5) tick();
      out_ready = 1;
      tick();
      chk("bp_reaccept", 32'(out_valid), 32'd1);
      in_valid = 0;
      tick();

      // Reseed with zero while a bundle is pending; stream must equal the post-reset stream.
      in_valid = 1; a = 1; b = 1; out_ready = 0;
      tick();
      in_valid = 0; seed_load = 1; seed_in = 0;
      tick();
      seed_load = 0;
      chk("sl_valid", 32'(out_valid), 32'd0);
      warm("warm_sl");
      stream(0);
      chk("replay_len", 32'(log_q.size()), 32'(ref_q.size()));
      for (int i = 0; i < 8; i++)
         if (i < log_q.size() && i < ref_q.size())
            chk($sformatf("replay%0d", i), 32'(log_q[i]), 32'(ref_q[i]));

      // Determinism across reloads of the same seed, divergence for another seed.
      det_run(32'h0000_0001); seq1 = log_q;
      det_run(32'h0000_0001); seq1b = log_q;
      det_run(32'h0000_0002); seq2 = log_q;
      chk("det_len", 32'(seq1.size() + seq1b.size() + seq2.size()), 32'd30);
      s1 = '0; s2 = '0;
      for (int i = 0; i < 10; i++) begin
         if (i < seq1.size() && i < seq1b.size())
            chk($sformatf("det%0d", i), 32'(seq1b[i]), 32'(seq1[i]));
         if (i < seq1.size()) s1[i*7 +: 7] = seq1[i];
         if (i < seq2.size()) s2[i*7 +: 7] = seq2[i];
      end
      checks++;
      assert (s1 !== s2) else begin
         failures++;
         $error("FAIL seed_diff observed=%0h expected=not %0h", s2, s1);
      end

      // seed_load colliding with an offered input in RUN.
      in_valid = 1; a = 1; b = 0; out_ready = 0;
      tick();
      seed_load = 1; seed_in = 32'h1234_5678;
      tick();
      seed_load = 0; in_valid = 0;
      chk("coll_valid", 32'(out_valid), 32'd0);
      chk("coll_busy", 32'(busy), 32'd1);
      warm("warm_coll");

      // Reset in the middle of backpressure.
      in_valid = 1; a = 1; b = 1; out_ready = 0;
      tick();
      in_valid = 0;
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("rst_mid_outs", 32'({out_valid, a0, a1, b0, b1, r0, r1, r2}), 32'd0);
      warm("warm_rst2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
